dm_lsu: RTL

//   Parametrised data memory with a load/store front end: byte/half/word stores via

---
 rtl/dm_lsu_if.sv | 18 +
 rtl/dm_lsu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/dm_lsu_if.sv
// Load/store request/response bundle between the MEM stage and dm_lsu.
interface dm_lsu_if #(parameter int ADDR_W = 12);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic              ready;
    logic              valid;
    logic [31:0]       dout;
    logic              misalign;

    modport master (output req, we, size, uns, addr, din,
                    input  ready, valid, dout, misalign);
    modport slave  (input  req, we, size, uns, addr, din,
                    output ready, valid, dout, misalign);
endinterface

// File: rtl/dm_lsu.sv
// Data memory with byte-lane stores, extended loads, misalignment faults
// and a req/ready/valid handshake with WAIT_CYC extra cycles per access.
module dm_lsu #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_lsu_if.slave  bus
);
    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]       mem [DEPTH];
    logic [3:0]        cnt;
    logic              r_we, r_uns;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic [31:0]       dout_q;
    logic              mis_q;

    logic              accept, go_done, fault, wr_en;
    logic              c_we, c_uns;
    logic [1:0]        c_size, lane;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_din, rword, wdata, ld_data;
    logic [3:0]        be;
    logic [7:0]        bsel;
    logic [15:0]       hsel;

    assign bus.ready    = (state == IDLE) && rst_n;
    assign bus.valid    = (state == DONE);
    assign bus.dout     = dout_q;
    assign bus.misalign = mis_q;
    assign accept       = bus.req && bus.ready;

    // The edge entering DONE comes straight from IDLE (no wait or fault)
    // or from BUSY, so the access fields are muxed between bus and latch.
    assign c_we   = (state == IDLE) ? bus.we   : r_we;
    assign c_uns  = (state == IDLE) ? bus.uns  : r_uns;
    assign c_size = (state == IDLE) ? bus.size : r_size;
    assign c_addr = (state == IDLE) ? bus.addr : r_addr;
    assign c_din  = (state == IDLE) ? bus.din  : r_din;
    assign lane   = c_addr[1:0];

    assign fault   = (c_size == 2'b11) || (c_size == 2'b01 && c_addr[0]) ||
                     (c_size == 2'b10 && c_addr[1:0] != 2'b00);
    assign go_done = (state == IDLE && accept && (WAIT_CYC == 0 || fault)) ||
                     (state == BUSY && cnt == 4'd0);
    assign wr_en   = go_done && c_we && !fault && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = go_done ? DONE : BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b0000;
        wdata = c_din;
        case (c_size)
            2'b00: begin be = 4'b0001 << lane; wdata = {4{c_din[7:0]}}; end
            2'b01: begin be = c_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{c_din[15:0]}}; end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rword = mem[c_addr[ADDR_W-1:2]];
    assign bsel  = 8'(rword >> {lane, 3'b000});
    assign hsel  = c_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (c_size)
            2'b00:   ld_data = c_uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            2'b01:   ld_data = c_uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            default: ld_data = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            r_we   <= 1'b0;
            r_uns  <= 1'b0;
            r_size <= 2'b00;
            r_addr <= '0;
            r_din  <= 32'd0;
            dout_q <= 32'd0;
            mis_q  <= 1'b0;
        end else begin
            if (accept) begin
                r_we   <= bus.we;
                r_uns  <= bus.uns;
                r_size <= bus.size;
                r_addr <= bus.addr;
                r_din  <= bus.din;
                cnt    <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go_done) begin
                dout_q <= (fault || c_we) ? 32'd0 : ld_data;
                mis_q  <= fault;
            end
        end
    end
endmodule
